// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
//
// Purpose:
//   Sequencing controller that sits between the debounced button block and
//   the seconds counter. It lets the user freeze time and edit a copy of the
//   counter value in second/minute/hour/day steps. The edit is then either
//   committed with a one-cycle active-low load strobe, or abandoned. An
//   abandoned edit can come from a cancel button or from an inactivity
//   timeout.
//
// Ports:
//   clk          in   1  system clock
//   reset_n      in   1  synchronous, active-low reset
//   btn_mode     in   1  pulse: enter edit from RUN / advance field in EDIT
//   btn_inc      in   1  pulse: add the step of the selected field
//   btn_dec      in   1  pulse: subtract the step of the selected field
//   btn_ok       in   1  pulse: commit the edit
//   btn_cancel   in   1  pulse: abandon the edit
//   counter_in   in   N  live counter value, captured on edit entry
//   go           out  1  counter run enable
//   load_n       out  1  active-low load strobe to the counter
//   set_counter  out  N  value to load (the edit register)
//   field_sel    out  2  0=sec, 1=min, 2=hour, 3=day
//   editing      out  1  high while editing (EDIT and the LOAD cycle)
// ---------------------------------------------------------------------------
module time_set_controller #(
  parameter int N       = 64,
  parameter int TIMEOUT = 30000000,
  parameter int TW      = 25
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         btn_mode,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic         btn_ok,
  input  logic         btn_cancel,
  input  logic [N-1:0] counter_in,
  output logic         go,
  output logic         load_n,
  output logic [N-1:0] set_counter,
  output logic [1:0]   field_sel,
  output logic         editing
);

  localparam logic [1:0]    S_RUN  = 2'd0;
  localparam logic [1:0]    S_EDIT = 2'd1;
  localparam logic [1:0]    S_LOAD = 2'd2;

  localparam logic [N-1:0]  MAX_VAL      = '1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic          r_go;
  logic          r_load_n;
  logic [N-1:0]  r_edit;
  logic [1:0]    r_field_sel;
  logic          r_editing;
  logic [TW-1:0] r_timeout;

  logic [N-1:0]  w_step;
  logic [N-1:0]  w_inc_val;
  logic [N-1:0]  w_dec_val;
  logic          w_any_btn;
  logic          w_timed_out;

  // Step size, in seconds, of the currently selected field.
  always_comb begin
    w_step = N'(1);
    case (r_field_sel)
      2'd0:    w_step = N'(1);
      2'd1:    w_step = N'(60);
      2'd2:    w_step = N'(3600);
      default: w_step = N'(86400);
    endcase
  end

  // Saturating arithmetic. The guards are written so that they never wrap.
  // Checking against MAX_VAL - step avoids needing an N+1 bit carry.
  assign w_inc_val = (r_edit > (MAX_VAL - w_step)) ? MAX_VAL : (r_edit + w_step);
  assign w_dec_val = (r_edit < w_step) ? '0 : (r_edit - w_step);

  assign w_any_btn   = btn_mode | btn_inc | btn_dec | btn_ok | btn_cancel;
  // An idle cycle that would push the count past TIMEOUT-1 acts as cancel.
  // The full window is then exactly TIMEOUT cycles long.
  assign w_timed_out = (r_timeout == TIMEOUT_LAST) && !w_any_btn;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_RUN;
      r_go        <= 1'b0;
      r_load_n    <= 1'b1;
      r_edit      <= '0;
      r_field_sel <= 2'd0;
      r_editing   <= 1'b0;
      r_timeout   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_load_n <= 1'b1;
          if (btn_mode) begin
            r_state     <= S_EDIT;
            r_edit      <= counter_in;
            r_go        <= 1'b0;
            r_field_sel <= 2'd0;
            r_editing   <= 1'b1;
            r_timeout   <= '0;
          end else begin
            r_go      <= 1'b1;
            r_editing <= 1'b0;
          end
        end

        S_EDIT: begin
          r_go     <= 1'b0;
          r_load_n <= 1'b1;
          r_timeout <= w_any_btn ? '0 : (r_timeout + TW'(1));
          if (btn_ok) begin
            r_state  <= S_LOAD;
            r_load_n <= 1'b0;
          end else if (btn_cancel || w_timed_out) begin
            // The counter was never loaded, so it resumes from its frozen value.
            r_state     <= S_RUN;
            r_go        <= 1'b1;
            r_editing   <= 1'b0;
            r_field_sel <= 2'd0;
            r_timeout   <= '0;
          end else if (btn_mode) begin
            r_field_sel <= r_field_sel + 2'd1;
          end else if (btn_inc && !btn_dec) begin
            r_edit <= w_inc_val;
          end else if (btn_dec && !btn_inc) begin
            r_edit <= w_dec_val;
          end
        end

        S_LOAD: begin
          // Single strobe cycle. Buttons pressed here are deliberately dropped.
          r_state     <= S_RUN;
          r_load_n    <= 1'b1;
          r_go        <= 1'b1;
          r_editing   <= 1'b0;
          r_field_sel <= 2'd0;
          r_timeout   <= '0;
        end

        default: begin
          r_state     <= S_RUN;
          r_go        <= 1'b0;
          r_load_n    <= 1'b1;
          r_editing   <= 1'b0;
          r_field_sel <= 2'd0;
          r_timeout   <= '0;
        end
      endcase
    end
  end

  assign go          = r_go;
  assign load_n      = r_load_n;
  assign set_counter = r_edit;
  assign field_sel   = r_field_sel;
  assign editing     = r_editing;

endmodule

// File: tb/tb_time_set_controller.sv
// ---------------------------------------------------------------------------
// tb_time_set_controller
//
// Purpose:
//   Directed-vector bench for time_set_controller. It uses a short timeout
//   so the auto-cancel behaviour can be exercised quickly. Inputs are changed
//   1 time unit after the rising edge, and outputs are checked at that same
//   point. Load strobes are counted on the falling edge.
// ---------------------------------------------------------------------------
module tb_time_set_controller;

  localparam int N       = 64;
  localparam int TIMEOUT = 20;
  localparam int TW      = 25;

  logic         clk;
  logic         resetN;
  logic         btnMode;
  logic         btnInc;
  logic         btnDec;
  logic         btnOk;
  logic         btnCancel;
  logic [N-1:0] counterIn;
  logic         go;
  logic         loadN;
  logic [N-1:0] setCounter;
  logic [1:0]   fieldSel;
  logic         editing;

  int checkCount = 0;
  int errorCount = 0;
  int loadLows   = 0;

  time_set_controller #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk         (clk),
    .reset_n     (resetN),
    .btn_mode    (btnMode),
    .btn_inc     (btnInc),
    .btn_dec     (btnDec),
    .btn_ok      (btnOk),
    .btn_cancel  (btnCancel),
    .counter_in  (counterIn),
    .go          (go),
    .load_n      (loadN),
    .set_counter (setCounter),
    .field_sel   (fieldSel),
    .editing     (editing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count the cycles in which the load strobe is asserted.
  always @(negedge clk) begin
    if (loadN === 1'b0) loadLows++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i, input logic d,
                       input logic o, input logic c);
    btnMode = m; btnInc = i; btnDec = d; btnOk = o; btnCancel = c;
    @(posedge clk);
    #1;
    btnMode = 0; btnInc = 0; btnDec = 0; btnOk = 0; btnCancel = 0;
  endtask

  task automatic test_reset();
    int lowsBefore;
    resetN = 1'b0;
    tick();
    tick();
    checkCount++;
    if (go !== 1'b0 || loadN !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL reset_outputs: go=%b load_n=%b, expected go=0 load_n=1", go, loadN);
    end
    checkCount++;
    if (setCounter !== '0 || fieldSel !== 2'd0 || editing !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_regs: set_counter=%0h field_sel=%0d editing=%b, expected 0/0/0",
               setCounter, fieldSel, editing);
    end
    resetN = 1'b1;
    tick();
    checkCount++;
    if (go !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL go_after_reset: go=%b, expected 1", go);
    end
    lowsBefore = loadLows;
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 0, 1, 0);
    tick();
    checkCount++;
    if (go !== 1'b1 || loadN !== 1'b1 || editing !== 1'b0 || loadLows != lowsBefore) begin
      errorCount++;
      $display("[TB] FAIL run_ignores_buttons: go=%b load_n=%b editing=%b loads=%0d, expected 1/1/0 loads=0",
               go, loadN, editing, loadLows - lowsBefore);
    end
  endtask

  task automatic test_commit();
    int lowsBefore;
    counterIn = 64'd1000;
    pulse(1, 0, 0, 0, 0);
    checkCount++;
    if (editing !== 1'b1 || go !== 1'b0 || setCounter !== 64'd1000 || fieldSel !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL edit_entry: editing=%b go=%b set_counter=%0d field=%0d, expected 1/0/1000/0",
               editing, go, setCounter, fieldSel);
    end
    pulse(1, 0, 0, 0, 0);
    checkCount++;
    if (fieldSel !== 2'd1) begin
      errorCount++;
      $display("[TB] FAIL field_to_min: field_sel=%0d, expected 1", fieldSel);
    end
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    checkCount++;
    if (setCounter !== 64'd1120) begin
      errorCount++;
      $display("[TB] FAIL min_inc: set_counter=%0d, expected 1120", setCounter);
    end
    lowsBefore = loadLows;
    pulse(0, 0, 0, 1, 0);
    checkCount++;
    if (loadN !== 1'b0 || go !== 1'b0 || setCounter !== 64'd1120) begin
      errorCount++;
      $display("[TB] FAIL load_cycle: load_n=%b go=%b set_counter=%0d, expected 0/0/1120",
               loadN, go, setCounter);
    end
    tick();
    checkCount++;
    if (loadN !== 1'b1 || go !== 1'b1 || editing !== 1'b0 || fieldSel !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL after_load: load_n=%b go=%b editing=%b field=%0d, expected 1/1/0/0",
               loadN, go, editing, fieldSel);
    end
    tick();
    checkCount++;
    if (loadLows - lowsBefore != 1) begin
      errorCount++;
      $display("[TB] FAIL load_pulse_width: low cycles=%0d, expected 1", loadLows - lowsBefore);
    end
  endtask

  task automatic test_saturation();
    logic [N-1:0] nearMax;
    logic [N-1:0] allOnes;
    nearMax = 64'hFFFF_FFFF_FFFF_FFF6;
    allOnes = '1;
    counterIn = 64'd5000;
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    checkCount++;
    if (fieldSel !== 2'd3) begin
      errorCount++;
      $display("[TB] FAIL field_to_day: field_sel=%0d, expected 3", fieldSel);
    end
    pulse(0, 0, 1, 0, 0);
    checkCount++;
    if (setCounter !== 64'd0) begin
      errorCount++;
      $display("[TB] FAIL day_dec_sat: set_counter=%0d, expected 0", setCounter);
    end
    pulse(0, 0, 1, 0, 0);
    checkCount++;
    if (setCounter !== 64'd0) begin
      errorCount++;
      $display("[TB] FAIL day_dec_hold: set_counter=%0d, expected 0", setCounter);
    end
    pulse(0, 0, 0, 0, 1);
    counterIn = nearMax;
    pulse(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) pulse(0, 1, 0, 0, 0);
    checkCount++;
    if (setCounter !== allOnes) begin
      errorCount++;
      $display("[TB] FAIL sec_inc_reach_max: set_counter=%0h, expected %0h", setCounter, allOnes);
    end
    pulse(0, 1, 0, 0, 0);
    checkCount++;
    if (setCounter !== allOnes) begin
      errorCount++;
      $display("[TB] FAIL sec_inc_sat: set_counter=%0h, expected %0h", setCounter, allOnes);
    end
    pulse(0, 0, 0, 0, 1);
  endtask

  task automatic test_cancel_timeout();
    int lowsBefore;
    lowsBefore = loadLows;
    counterIn = 64'd777;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    checkCount++;
    if (setCounter !== 64'd778) begin
      errorCount++;
      $display("[TB] FAIL cancel_pre_edit: set_counter=%0d, expected 778", setCounter);
    end
    pulse(0, 0, 0, 0, 1);
    checkCount++;
    if (go !== 1'b1 || editing !== 1'b0 || loadN !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL cancel: go=%b editing=%b load_n=%b, expected 1/0/1", go, editing, loadN);
    end
    pulse(1, 0, 0, 0, 0);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    checkCount++;
    if (editing !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL timeout_early: editing=%b after %0d idle cycles, expected 1", editing, TIMEOUT - 1);
    end
    tick();
    checkCount++;
    if (editing !== 1'b0 || go !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL timeout_cancel: editing=%b go=%b, expected 0/1", editing, go);
    end
    pulse(1, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) tick();
    pulse(0, 1, 0, 0, 0);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    checkCount++;
    if (editing !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL timeout_restart: editing=%b, expected 1", editing);
    end
    tick();
    checkCount++;
    if (editing !== 1'b0 || go !== 1'b1 || loadLows != lowsBefore) begin
      errorCount++;
      $display("[TB] FAIL timeout_restart_cancel: editing=%b go=%b loads=%0d, expected 0/1/0",
               editing, go, loadLows - lowsBefore);
    end
  endtask

  task automatic test_simultaneous();
    counterIn = 64'd100;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 1, 0, 0);
    checkCount++;
    if (setCounter !== 64'd100) begin
      errorCount++;
      $display("[TB] FAIL inc_dec_together: set_counter=%0d, expected 100", setCounter);
    end
    pulse(1, 1, 0, 0, 0);
    checkCount++;
    if (fieldSel !== 2'd1 || setCounter !== 64'd100) begin
      errorCount++;
      $display("[TB] FAIL mode_inc: field=%0d set_counter=%0d, expected 1/100", fieldSel, setCounter);
    end
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    checkCount++;
    if (fieldSel !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL field_wrap: field_sel=%0d, expected 0", fieldSel);
    end
    pulse(0, 0, 0, 1, 1);
    checkCount++;
    if (loadN !== 1'b0 || setCounter !== 64'd100) begin
      errorCount++;
      $display("[TB] FAIL ok_beats_cancel: load_n=%b set_counter=%0d, expected 0/100", loadN, setCounter);
    end
    tick();
    checkCount++;
    if (go !== 1'b1 || loadN !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL ok_cancel_return: go=%b load_n=%b, expected 1/1", go, loadN);
    end
  endtask

  task automatic test_reset_mid_load();
    int lowsBefore;
    counterIn = 64'd42;
    pulse(1, 0, 0, 0, 0);
    lowsBefore = loadLows;
    pulse(0, 0, 0, 1, 0);
    checkCount++;
    if (loadN !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL mid_load_enter: load_n=%b, expected 0", loadN);
    end
    resetN = 1'b0;
    tick();
    checkCount++;
    if (loadN !== 1'b1 || go !== 1'b0 || setCounter !== '0 || editing !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_in_load: load_n=%b go=%b set_counter=%0d editing=%b, expected 1/0/0/0",
               loadN, go, setCounter, editing);
    end
    tick();
    resetN = 1'b1;
    tick();
    tick();
    checkCount++;
    if (go !== 1'b1 || loadN !== 1'b1 || setCounter !== '0 || loadLows - lowsBefore != 1) begin
      errorCount++;
      $display("[TB] FAIL post_reset: go=%b load_n=%b set_counter=%0d loads=%0d, expected 1/1/0 loads=1",
               go, loadN, setCounter, loadLows - lowsBefore);
    end
  endtask

  initial begin
    resetN = 1'b0;
    btnMode = 0; btnInc = 0; btnDec = 0; btnOk = 0; btnCancel = 0;
    counterIn = '0;
    test_reset();
    test_commit();
    test_saturation();
    test_cancel_timeout();
    test_simultaneous();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequencing controller for the seconds counter (64-bit count, 1 Hz tick, synchronous load via load_n/set value, run-enable go).
- Owns go and load_n.
- Lets the user freeze time, edit the captured value in second/minute/hour/day steps, then commit it with a one-cycle load pulse, or abandon the edit.
- Sits between the debounced button block and the counter.

Parameters:
- N, 64, counter width; edit register and set_counter width.
- TIMEOUT, 30000000, clk cycles of no button activity in EDIT before an automatic cancel.
- TW, 25, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- btn_mode  in  1  one-cycle pulse: enter edit from RUN / advance field in EDIT.
- btn_inc  in  1  one-cycle pulse: add step of selected field.
- btn_dec  in  1  one-cycle pulse: subtract step of selected field.
- btn_ok  in  1  one-cycle pulse: commit edit.
- btn_cancel  in  1  one-cycle pulse: abandon edit.
- counter_in  in  N  live counter value.
- go  out  1  counter run enable.
- load_n  out  1  active-low load strobe to counter.
- set_counter  out  N  value to load; equals edit register.
- field_sel  out  2  0=sec, 1=min, 2=hour, 3=day.
- editing  out  1  high while in EDIT.

Behaviour:
- Clock and reset: clk; reset reset_n, synchronous, active-low. All outputs registered.
- Reset values: state=RUN, go=0, load_n=1, set_counter=0, field_sel=0, editing=0, timeout counter=0.
- go becomes 1 on the first clock after reset_n deasserts.
- States: RUN, EDIT, LOAD.
- RUN: go=1, load_n=1, editing=0.
  - btn_mode -> EDIT next cycle.
  - In that cycle: edit<=counter_in, go<=0, field_sel<=0, editing<=1, timeout<=0.
  - All other buttons are ignored.
- EDIT: go=0, load_n=1.
  - Field steps: sec=1, min=60, hour=3600, day=86400.
  - Priority when buttons coincide: ok > cancel > mode > inc/dec.
  - btn_ok -> LOAD.
  - btn_cancel -> RUN; go<=1, edit discarded, counter resumes from its frozen value.
  - btn_mode -> field_sel<=field_sel+1, wrapping 3->0.
  - btn_inc alone -> edit<=edit+step. Saturates at 2^N-1 when edit > 2^N-1-step.
  - btn_dec alone -> edit<=edit-step. Saturates at 0 when edit < step.
  - btn_inc and btn_dec together -> no change.
  - Any button pulse clears the timeout counter. Otherwise it increments each cycle.
  - Timeout reaching TIMEOUT-1 with no button that cycle -> behaves as btn_cancel.
- LOAD: exactly one cycle.
  - load_n=0, set_counter=edit (stable since EDIT), go=0.
  - Next cycle: RUN, load_n=1, go=1, editing=0, field_sel=0.
  - All buttons in LOAD are ignored.
- Latency:
  - btn_ok to load_n low: 1 cycle.
  - load_n low to go high: 1 cycle.
- set_counter changes only in EDIT (capture or inc/dec).
- reset_n low in any state, including LOAD, forces the reset values on the next edge. No load pulse completes after reset.

Test Plan:
- Reset then idle:
  - During reset: go=0, load_n=1.
  - One cycle after release: go=1.
  - btn_inc/dec/ok ignored in RUN, no load pulse.
- Enter edit and commit:
  - Stimulus: counter_in=1000; mode, field->min via mode, 2x inc, ok.
  - set_counter=1120; load_n low for exactly one cycle, 1 cycle after ok; go=1 the following cycle.
- Day field saturation:
  - Stimulus: counter_in=5000, field=day; dec.
  - Edit=0; a further dec keeps 0.
  - Capture 2^64-10, field=sec, inc x11 -> 2^64-1.
- Cancel and timeout:
  - Cancel after edits -> RUN, go=1, no load_n pulse.
  - With TIMEOUT=20 and no buttons, auto-cancel after 20 cycles.
  - A btn_inc at cycle 15 restarts the timeout count.
- Simultaneous buttons:
  - inc+dec in one cycle -> edit unchanged.
  - ok+cancel -> LOAD.
  - mode+inc -> field advances only.
  - field wraps 3->0 on 4th mode.
- Reset mid-operation:
  - reset_n low during LOAD cycle -> load_n=1, go=0, state RUN.
  - Post-reset set_counter=0 with no stale pulse.
